button_conditioner: RTL and testbench

- Front-end input stage for the game top-level: synchronizes, debounces and edge-detects the raw push-buttons (select, move, attack) before they reach the FSM and the movement/attack logic.
- Emits a clean level, a single-cycle press pulse and a single-cycle release pulse per button, all on the system clock.
- Without this stage the FSM sees a held KEY as many presses, which causes multiple moves and attacks.

---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_channel.sv | 163 ++++++++++++++++
 rtl/button_conditioner.sv | 36 +++
 tb/tb_button_conditioner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and channel indices for the push-button front end.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned BTN_SELECT = 0;
  localparam int unsigned BTN_MOVE   = 1;
  localparam int unsigned BTN_ATTACK = 2;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce FSM and registered level/press/release outputs.
// Optional auto-repeat of press pulses while held when BTN_REPEAT_EN is defined.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned   CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q, s;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_evt, release_evt, rep_evt;
  logic             pend_press_q, pend_release_q;
  logic             level_q, press_q, release_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter is reloaded on every state change so it never needs to wrap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HELD;
          cnt_d     = '0;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          release_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end

  // Counts only while staying in HELD; any other cycle rearms the initial delay.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_evt     = 1'b0;
    if (state_q == HELD && s) begin
      if (rep_cnt_q == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
        rep_evt     = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end else begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end
  end
`else
  assign rep_evt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_press_q   <= 1'b0;
      pend_release_q <= 1'b0;
      level_q        <= 1'b0;
      press_q        <= 1'b0;
      release_q      <= 1'b0;
    end else begin
      pend_press_q   <= press_evt | rep_evt;
      pend_release_q <= release_evt;
      level_q        <= (state_q == HELD) || (state_q == RELEASE_WAIT);
      press_q        <= pend_press_q;
      release_q      <= pend_release_q;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into clean level, press and release signals.
// Auto-repeat of press pulses is built only when BTN_REPEAT_EN is defined.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (btn_raw_i[g]),
      .level_o  (btn_level_o[g]),
      .press_o  (btn_press_o[g]),
      .release_o(btn_release_o[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized bench for button_conditioner against a sample-run reference model.
module tb_button_conditioner;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] level, press, rel;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw_i(btn_raw),
    .btn_level_o(level), .btn_press_o(press), .btn_release_o(rel)
  );

  // Reference model: accepted level flips after DB consecutive samples that differ from it.
  logic [N-1:0] samp_q[$];
  bit           m_acc[N];
  int           m_run[N];
  int           m_k[N];
  bit           m_pp[N], m_pr[N];
  logic [N-1:0] e_level, e_press, e_rel;

  function automatic bit rep_hit(input int k);
    return (k == RD) || (k > RD && ((k - RD) % RP) == 0);
  endfunction

  task automatic model_reset();
    samp_q = {};
    samp_q.push_back('1);
    samp_q.push_back('1);
    for (int c = 0; c < N; c++) begin
      m_acc[c] = 0; m_run[c] = 0; m_k[c] = 0; m_pp[c] = 0; m_pr[c] = 0;
    end
    e_level = '0; e_press = '0; e_rel = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    logic [N-1:0] s;
    samp_q.push_back(raw);
    s = ~samp_q.pop_front();
    for (int c = 0; c < N; c++) begin
      e_level[c] = m_acc[c];
      e_press[c] = m_pp[c];
      e_rel[c]   = m_pr[c];
      m_pp[c] = 0;
      m_pr[c] = 0;
      if (bit'(s[c]) == m_acc[c]) begin
        if (m_acc[c] && m_run[c] == 0) begin
          m_k[c]++;
          if (REP && rep_hit(m_k[c])) m_pp[c] = 1;
        end else begin
          m_k[c] = 0;
        end
        m_run[c] = 0;
      end else begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_acc[c] = s[c];
          m_run[c] = 0;
          m_k[c]   = 0;
          if (s[c]) m_pp[c] = 1;
          else      m_pr[c] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [N-1:0] raw);
    btn_raw = raw;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(raw);
    @(negedge clk);
    chk("level", level, e_level);
    chk("press", press, e_press);
    chk("release", rel, e_rel);
    chk("press_and_release", press & rel, '0);
  endtask

  int cnt_a, cnt_b, cnt_c, zrun;
  logic [N-1:0] r;
  int hold[N];

  initial begin
    rst = 1'b0;
    btn_raw = '1;
    #2;
    // Reset with every button pressed: outputs forced low immediately.
    rst = 1'b1;
    btn_raw = 3'b000;
    model_reset();
    #1;
    chk("reset_level", level, '0);
    chk("reset_press", press, '0);
    chk("reset_release", rel, '0);
    for (int i = 0; i < 3; i++) tick(3'b000);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(3'b000);
      chk("post_reset_press", press, (i == 7) ? 3'b111 : 3'b000);
    end
    for (int i = 0; i < 12; i++) tick(3'b111);

    // Clean press and release on channel 1.
    cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(3'b101);
      if (i == 7) chk("ch1_press_at_7", press, 3'b010);
      cnt_a += press[1];
    end
    chk("ch1_level_held", level, 3'b010);
    for (int i = 1; i <= 20; i++) begin
      tick(3'b111);
      if (i == 7) chk("ch1_release_at_7", rel, 3'b010);
      cnt_b += rel[1];
    end
    chk_int("ch1_press_count", cnt_a, 1);
    chk_int("ch1_release_count", cnt_b, 1);
    chk("ch1_level_released", level, 3'b000);

    // Bounce on channel 0: low pulses of 1-2 cycles never reach the debounce length.
    cnt_a = 0; zrun = 0;
    for (int i = 0; i < 15; i++) begin
      r = 3'b111;
      if (zrun < 2 && ($urandom % 2) == 1) begin r[0] = 1'b0; zrun++; end
      else zrun = 0;
      tick(r);
      chk("bounce_level", level, 3'b000);
      cnt_a += press[0];
    end
    for (int i = 0; i < 10; i++) begin
      tick(3'b111);
      cnt_a += press[0] + rel[0];
    end
    chk_int("bounce_pulses", cnt_a, 0);

    // Channels 0 and 2 pressed together.
    cnt_a = 0; cnt_c = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(3'b010);
      if (i == 7) chk("simul_press", press, 3'b101);
      cnt_a += press[0];
      cnt_c += press[2];
    end
    chk_int("simul_ch0_count", cnt_a, 1);
    chk_int("simul_ch2_count", cnt_c, 1);
    for (int i = 0; i < 12; i++) tick(3'b111);

    // Reset while channel 1 is part-way through press debounce.
    for (int i = 0; i < 4; i++) tick(3'b101);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midpress_reset_outputs", level | press | rel, '0);
    for (int i = 0; i < 2; i++) tick(3'b101);
    rst = 1'b0;
    cnt_a = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(3'b101);
      chk("midpress_after_reset", press, (i == 7) ? 3'b010 : 3'b000);
      cnt_a += press[1];
    end
    chk_int("midpress_press_count", cnt_a, 1);
    for (int i = 0; i < 12; i++) tick(3'b111);

    // Long hold on channel 1: one press, plus repeats when auto-repeat is built.
    cnt_a = 0;
    for (int i = 0; i < 52; i++) begin tick(3'b101); cnt_a += press[1]; end
    for (int i = 0; i < 10; i++) begin tick(3'b111); cnt_a += press[1]; end
    chk_int("long_hold_presses", cnt_a, REP ? 5 : 1);

    // Random holds per channel, checked cycle by cycle against the model.
    r = 3'b111;
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          r[c] = ~r[c];
          hold[c] = $urandom_range(1, 12);
        end
        hold[c]--;
      end
      tick(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
